// File: rtl/echo_seq_pkg.sv
// echo_seq_pkg: shared states and constants for the echo ping sequencer
package echo_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_TX, S_BLANK, S_LISTEN, S_REPORT, S_GAP, S_ACCUM} state_e;
  localparam int DEF_TX_CYCLES = 5000;
  localparam int DEF_BLANK_CYCLES = 2000;
  localparam int DEF_LISTEN_CYCLES = 200000;
  localparam int DEF_GAP_CYCLES = 50000;
  localparam int DEF_CNT_W = 20;
  localparam logic [31:0] TOF_TIMEOUT = '1;
  localparam int AVG_N = 4;
  localparam int AVG_SHIFT = 2;
endpackage

// File: rtl/echo_ping_sequencer_timer.sv
// seq_timer: loadable down-counter, done while the count is zero
// Ports: clk_i clock, rst_ni sync active-low reset, load_i/val_i reload,
//        en_i count enable, done_o count reached zero
module seq_timer #(
  parameter int W = 20
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? val_i : (en_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign done_o = cnt_q == '0;
endmodule

// File: rtl/echo_ping_sequencer.sv
// echo_ping_sequencer: sequences TX burst, blanking, listen window and time-of-flight report
// Ports: sys_clk/sys_res_n clock and sync active-low reset; start/stop/cont_mode control;
//        echo_det/ad_otr receiver status; da_tx_en/ad_capture_en/busy status;
//        res_valid/res_ready/res_tof/res_timeout/res_otr result handshake; ping_cnt reports done.
// Macro ECHO_AVG_EN: average 4 pings into each report.
module echo_ping_sequencer
  import echo_seq_pkg::*;
#(
  parameter int TX_CYCLES = DEF_TX_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int LISTEN_CYCLES = DEF_LISTEN_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             sys_clk,
  input  logic             sys_res_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cont_mode,
  input  logic             echo_det,
  input  logic             ad_otr,
  output logic             da_tx_en,
  output logic             ad_capture_en,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_tof,
  output logic             res_timeout,
  output logic             res_otr,
  output logic [15:0]      ping_cnt
);
`ifdef ECHO_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif
  localparam logic [CNT_W-1:0] TX_LD = CNT_W'(TX_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LISTEN_LD = CNT_W'(LISTEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYCLES - 1);
  state_e state_q, state_d;
  logic cont_q, cont_d, stop_pend_q, stop_pend_d, echo_prev_q, otr_q, otr_d;
  logic res_to_q, res_to_d, res_otr_q, res_otr_d, avg_to_q, avg_to_d, avg_otr_q, avg_otr_d;
  logic [CNT_W-1:0] tof_q, tof_d, res_tof_q, res_tof_d, tmr_val, hit_tof;
  logic [CNT_W+1:0] sum_q, sum_d, hit_sum;
  logic [15:0] ping_q, ping_d;
  logic [1:0] avg_q, avg_d;
  logic echo, stop_any, last_ping, listen_end, avg_clr, hit_otr, tmr_done;
  assign echo = echo_det & ~echo_prev_q;
  assign stop_any = stop | stop_pend_q;
  assign last_ping = !AVG || avg_q == 2'(AVG_N - 1);
  assign listen_end = state_q == S_LISTEN && (echo || tmr_done);
  assign hit_tof = echo ? tof_q : TOF_TIMEOUT[CNT_W-1:0];
  assign hit_otr = otr_q | ad_otr;
  assign hit_sum = sum_q + {2'b00, hit_tof};
  assign avg_clr = state_q == S_IDLE || (listen_end && last_ping);
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = start ? S_TX : S_IDLE;
      S_TX:     if (tmr_done) state_d = BLANK_CYCLES == 0 ? S_LISTEN : S_BLANK;
      S_BLANK:  if (tmr_done) state_d = S_LISTEN;
      S_LISTEN: if (echo || tmr_done) state_d = last_ping ? S_REPORT : S_ACCUM;
      S_REPORT: if (res_ready) state_d = (cont_q && !stop_any) ? (GAP_CYCLES == 0 ? S_TX : S_GAP) : S_IDLE;
      S_ACCUM:  state_d = stop_any ? S_IDLE : (cont_q && GAP_CYCLES != 0) ? S_GAP : S_TX;
      S_GAP:    state_d = stop_any ? S_IDLE : tmr_done ? S_TX : S_GAP;
      default:  state_d = S_IDLE;
    endcase
  end
  always_comb begin
    tmr_val = state_d == S_TX ? TX_LD : state_d == S_BLANK ? BLANK_LD : state_d == S_LISTEN ? LISTEN_LD : GAP_LD;
    cont_d = (state_q == S_IDLE && start) ? cont_mode : cont_q;
    stop_pend_d = state_q == S_IDLE ? start & stop : stop_pend_q | stop;
    tof_d = state_q inside {S_TX, S_BLANK, S_LISTEN} ? (&tof_q ? tof_q : tof_q + CNT_W'(1)) : '0;
    otr_d = state_q == S_LISTEN ? hit_otr : 1'b0;
    res_tof_d = (listen_end && last_ping) ? (AVG ? CNT_W'(hit_sum >> AVG_SHIFT) : hit_tof) : res_tof_q;
    res_to_d = (listen_end && last_ping) ? !echo | avg_to_q : res_to_q;
    res_otr_d = (listen_end && last_ping) ? hit_otr | avg_otr_q : res_otr_q;
    sum_d = avg_clr ? '0 : listen_end ? hit_sum : sum_q;
    avg_d = avg_clr ? '0 : listen_end ? avg_q + 2'd1 : avg_q;
    avg_to_d = avg_clr ? 1'b0 : listen_end ? avg_to_q | !echo : avg_to_q;
    avg_otr_d = avg_clr ? 1'b0 : listen_end ? avg_otr_q | hit_otr : avg_otr_q;
    ping_d = ping_q + 16'(state_q == S_REPORT && res_ready);
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_res_n) begin
      state_q <= S_IDLE;
      cont_q <= 1'b0;
      stop_pend_q <= 1'b0;
      echo_prev_q <= 1'b0;
      otr_q <= 1'b0;
      tof_q <= '0;
      res_tof_q <= '0;
      res_to_q <= 1'b0;
      res_otr_q <= 1'b0;
      sum_q <= '0;
      avg_q <= '0;
      avg_to_q <= 1'b0;
      avg_otr_q <= 1'b0;
      ping_q <= '0;
    end else begin
      state_q <= state_d;
      cont_q <= cont_d;
      stop_pend_q <= stop_pend_d;
      echo_prev_q <= echo_det;
      otr_q <= otr_d;
      tof_q <= tof_d;
      res_tof_q <= res_tof_d;
      res_to_q <= res_to_d;
      res_otr_q <= res_otr_d;
      sum_q <= sum_d;
      avg_q <= avg_d;
      avg_to_q <= avg_to_d;
      avg_otr_q <= avg_otr_d;
      ping_q <= ping_d;
    end
  end
  seq_timer #(.W(CNT_W)) u_timer (
    .clk_i(sys_clk),
    .rst_ni(sys_res_n),
    .load_i(state_d != state_q),
    .en_i(state_q != S_IDLE),
    .val_i(tmr_val),
    .done_o(tmr_done)
  );
  assign da_tx_en = state_q == S_TX;
  assign ad_capture_en = state_q == S_LISTEN;
  assign busy = state_q != S_IDLE;
  assign res_valid = state_q == S_REPORT;
  assign res_tof = res_tof_q;
  assign res_timeout = res_to_q;
  assign res_otr = res_otr_q;
  assign ping_cnt = ping_q;
endmodule

// File: doc/echo_ping_sequencer.md
Name: echo_ping_sequencer

Overview:
- Sequences one acoustic ping measurement: drives the DA burst enable, blanks the receiver, opens the AD capture/listen window, and timestamps the first echo from pulse detection.
- Hands each time-of-flight result to the UDP transmit path through a valid/ready handshake.
- Sits between the system control logic (start/stop/mode) and the DA sender, AD receiver and UDP TX datapath.

Parameters:
- TX_CYCLES, 5000, DA burst length in sys_clk cycles (>=1)
- BLANK_CYCLES, 2000, receiver blanking after burst end (>=0)
- LISTEN_CYCLES, 200000, listen window length (>=1); no echo in window = timeout
- GAP_CYCLES, 50000, idle gap between pings in continuous mode (>=0)
- CNT_W, 20, width of timer and time-of-flight counters; each cycle parameter must be < 2^CNT_W

Ports:
- sys_clk in 1: single clock
- sys_res_n in 1: synchronous reset, active-low
- start in 1: 1-cycle pulse, begin measurement
- stop in 1: 1-cycle pulse, abort after current state
- cont_mode in 1: 0 = single ping, 1 = repeat until stop; sampled at start
- echo_det in 1: pulse-detection output, level or pulse
- ad_otr in 1: AD over-range
- da_tx_en out 1: DA burst enable
- ad_capture_en out 1: AD write/capture enable
- busy out 1: high in every state except IDLE
- res_valid out 1: result available
- res_ready in 1: UDP TX accepts result
- res_tof out CNT_W: cycles from burst start to echo rising edge
- res_timeout out 1: no echo in window
- res_otr out 1: ad_otr seen during LISTEN
- ping_cnt out 16: completed pings, wraps at 0xFFFF -> 0

Behaviour:
- Reset: all outputs 0, state IDLE, counters cleared. Reset mid-operation returns to IDLE on the next edge and drops da_tx_en the same edge.
- States: IDLE, TX, BLANK, LISTEN, REPORT, GAP.
- IDLE: start -> TX and latch cont_mode. tof counter = 0.
- TX: da_tx_en=1 for exactly TX_CYCLES cycles. The tof counter runs from the first TX cycle.
- BLANK: lasts BLANK_CYCLES cycles and ignores echo_det. If BLANK_CYCLES=0, go directly TX -> LISTEN.
- LISTEN: ad_capture_en=1. echo is a rising edge of echo_det (registered previous value).
  - On the first edge: latch res_tof = tof counter value that cycle -> REPORT, res_timeout=0.
  - After LISTEN_CYCLES cycles with no edge: res_tof = all ones, res_timeout=1 -> REPORT.
  - An echo edge in the final window cycle counts as an echo.
  - Sticky res_otr is cleared at LISTEN entry and set by ad_otr.
- REPORT: res_valid=1 with res_tof, res_timeout and res_otr held stable until res_valid&&res_ready (at least 1 cycle). The state is entered with res_valid set the same edge. On acceptance: ping_cnt++, and go to GAP if cont_mode and no stop is pending, else IDLE.
- GAP: GAP_CYCLES idle, then TX. GAP_CYCLES=0 -> straight to TX.
- stop: sets stop_pending in any non-IDLE state. The current ping completes through REPORT, then IDLE. stop in GAP -> IDLE next edge. stop_pending clears in IDLE.
- start while busy is ignored. start and stop in the same IDLE cycle: start wins, stop_pending is set, and a single ping runs.
- The tof counter saturates at all ones (no wrap).

Optional Feature:
- Macro ECHO_AVG_EN.
- Defined: 4 pings per report. REPORT is replaced internally by ACCUM for pings 1-3: accumulate tof into a CNT_W+2 sum, then GAP (or TX directly if single mode). On the 4th ping, res_tof = sum>>2.
  - res_timeout=1 if any of the 4 timed out; res_otr = OR of the 4.
  - ping_cnt increments per report.
  - stop aborts the averaging set at the next ping boundary with no report.
- Undefined: one report per ping as above.

Decomposition:
- Package echo_seq_pkg:
  - state enum
  - default cycle constants
  - TOF_TIMEOUT = all ones
  - AVG_N=4, AVG_SHIFT=2
- Sub-module seq_timer: loadable down-counter with load/en/done, instantiated once and reloaded per state.

Test Plan:
- Run with TX=10, BLANK=5, LISTEN=100. Pulse start, echo_det rising at cycle 40 after TX start -> da_tx_en high cycles 0-9; res_valid with res_tof=40, res_timeout=0, ping_cnt=1.
- No echo -> res_valid at cycle 115, res_tof=0xFFFFF, res_timeout=1.
- echo_det pulse during BLANK at cycle 12, then rising at 60 -> res_tof=60.
- cont_mode=1, GAP=20, res_ready held low 30 cycles -> result stable until accept. Next TX starts 21 cycles after accept. Issue stop during the 2nd LISTEN -> 2nd report delivered, then IDLE, ping_cnt=2.
- Assert sys_res_n low during TX -> next edge da_tx_en=0, busy=0, no res_valid.
- ECHO_AVG_EN with echoes at 40, 44, 48, 52 -> one report, res_tof=46. Repeat with the 3rd ping timing out -> res_timeout=1.
